spi_ram_burst_slave: RTL and testbench

SPI slave with an integrated single-port RAM and a parametrised address/data width. It succeeds the fixed 8-bit SPI-to-RAM top level. It keeps the four single-word commands (write address, write data, read address, read data) bit-compatible at the default parameters. It adds burst write and burst read with address auto-increment, plus a command-error flag. It sits directly behind the chip's SPI pins; MOSI and SS_n are sampled on the system clock.

---
 rtl/spi_ram_burst_slave.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_spi_ram_burst_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_burst_slave.sv
// -----------------------------------------------------------------------------
// spi_ram_burst_slave
//
// SPI slave with an integrated single-port RAM. The host frames each
// transaction with SS_n low and shifts a 3-bit command, MSB first, on MOSI.
// Depending on the command, an address field, one or more data words, or a
// dummy field follows. Read data comes back on MISO, MSB first.
//
// The four single-word commands match the older fixed 8-bit SPI-to-RAM top
// level at the default parameters. On top of those, this block adds:
//   - burst write and burst read, with the address auto-incrementing;
//   - a one-cycle error pulse when the command is undefined.
//
// MOSI and SS_n are sampled directly on the system clock. Each clk edge
// carries one serial bit.
//
// Commands:
//   000 WR_ADDR   110 RD_ADDR   001 WR_DATA   111 RD_DATA
//   010 WR_BURST  101 RD_BURST  011/100 undefined (cmd_err)
//
// Parameters:
//   MEM_DEPTH  number of RAM words (MEM_DEPTH <= 2**ADDR_SIZE)
//   ADDR_SIZE  address field width in bits
//   DATA_SIZE  data word width in bits
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   SS_n     slave select, active low
//   MOSI     serial data in, MSB first
//   MISO     serial data out, registered, MSB first
//   cmd_err  one-cycle pulse after an undefined command
// -----------------------------------------------------------------------------
module spi_ram_burst_slave #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic cmd_err
);

  // The input shifter must hold the widest field it ever has to collect:
  // the command, the address or a data word.
  localparam int SHW_A = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE;
  localparam int SHW   = (SHW_A > 3) ? SHW_A : 3;
  localparam int CNTW  = $clog2(SHW + 1);
  localparam int IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Depth constants are one bit wider than a pointer, so MEM_DEPTH == 2**ADDR_SIZE
  // is still representable.
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] LASTP_C = (ADDR_SIZE+1)'(MEM_DEPTH - 1);

  localparam logic [CNTW-1:0] CMD_LAST_C  = CNTW'(2);
  localparam logic [CNTW-1:0] ADDR_LAST_C = CNTW'(ADDR_SIZE - 1);
  localparam logic [CNTW-1:0] DATA_LAST_C = CNTW'(DATA_SIZE - 1);

  localparam logic [2:0] CMD_WR_ADDR  = 3'b000;
  localparam logic [2:0] CMD_WR_DATA  = 3'b001;
  localparam logic [2:0] CMD_WR_BURST = 3'b010;
  localparam logic [2:0] CMD_RD_BURST = 3'b101;
  localparam logic [2:0] CMD_RD_ADDR  = 3'b110;
  localparam logic [2:0] CMD_RD_DATA  = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDUMMY,
    RGAP,
    RSHIFT,
    IGNORE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [SHW-2:0]         in_q, in_d;
  logic [2:0]             cmd_q, cmd_d;
  logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_SIZE-1:0]   sh_q, sh_d;
  logic                   miso_q, miso_d;
  logic                   cmd_err_q, cmd_err_d;

  logic [SHW-1:0]         in_shift;
  logic [DATA_SIZE-1:0]   rd_word;
  logic                   mem_we;

  logic [DATA_SIZE-1:0]   mem [MEM_DEPTH];

  // Only the low SHW-1 bits are stored. The bit on MOSI completes the field
  // combinationally, so a field is usable on the same edge as its LSB.
  assign in_shift = {in_q, MOSI};

  function automatic logic inRange(input logic [ADDR_SIZE-1:0] p);
    return {1'b0, p} < DEPTH_C;
  endfunction

  // Addresses at or beyond the last word wrap to 0. Out-of-range pointers
  // also wrap to 0.
  function automatic logic [ADDR_SIZE-1:0] nextPtr(input logic [ADDR_SIZE-1:0] p);
    logic [ADDR_SIZE-1:0] r;
    if ({1'b0, p} >= LASTP_C) r = '0;
    else                      r = p + ADDR_SIZE'(1);
    return r;
  endfunction

  // Asynchronous RAM read at the read pointer. Out-of-range addresses read
  // as zero.
  always_comb begin
    rd_word = '0;
    if (inRange(rd_ptr_q)) rd_word = mem[rd_ptr_q[IDXW-1:0]];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_d      = in_q;
    cmd_d     = cmd_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sh_d      = sh_q;
    miso_d    = 1'b0;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;

    if (SS_n) begin
      // Deselect discards any partial field. The pointers keep their last
      // completed values.
      state_d = IDLE;
      cnt_d   = '0;
      in_d    = '0;
      sh_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Dead cycle: MOSI is not sampled on the select edge.
          state_d = CMD;
          cnt_d   = '0;
        end

        CMD: begin
          in_d  = in_shift[SHW-2:0];
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CMD_LAST_C) begin
            cnt_d = '0;
            cmd_d = in_shift[2:0];
            unique case (in_shift[2:0])
              CMD_WR_ADDR, CMD_RD_ADDR,
              CMD_WR_BURST, CMD_RD_BURST: state_d = ADDR;
              CMD_WR_DATA:                state_d = WDATA;
              CMD_RD_DATA:                state_d = RDUMMY;
              default: begin
                state_d   = IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end

        ADDR: begin
          in_d  = in_shift[SHW-2:0];
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == ADDR_LAST_C) begin
            cnt_d = '0;
            unique case (cmd_q)
              CMD_WR_ADDR: begin
                wr_ptr_d = in_shift[ADDR_SIZE-1:0];
                state_d  = IGNORE;
              end
              CMD_WR_BURST: begin
                wr_ptr_d = in_shift[ADDR_SIZE-1:0];
                state_d  = WDATA;
              end
              CMD_RD_BURST: begin
                rd_ptr_d = in_shift[ADDR_SIZE-1:0];
                state_d  = RGAP;
              end
              default: begin
                rd_ptr_d = in_shift[ADDR_SIZE-1:0];
                state_d  = IGNORE;
              end
            endcase
          end
        end

        WDATA: begin
          in_d  = in_shift[SHW-2:0];
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == DATA_LAST_C) begin
            // The word is committed on the edge that samples its LSB.
            cnt_d  = '0;
            mem_we = inRange(wr_ptr_q);
            if (cmd_q == CMD_WR_BURST) wr_ptr_d = nextPtr(wr_ptr_q);
            else                       state_d  = IGNORE;
          end
        end

        RDUMMY: begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == DATA_LAST_C) begin
            cnt_d   = '0;
            state_d = RGAP;
          end
        end

        RGAP: begin
          // Fetch the first word. Its MSB appears on MISO on the next edge.
          sh_d    = rd_word;
          cnt_d   = '0;
          state_d = RSHIFT;
          if (cmd_q == CMD_RD_BURST) rd_ptr_d = nextPtr(rd_ptr_q);
        end

        RSHIFT: begin
          miso_d = sh_q[DATA_SIZE-1];
          sh_d   = sh_q << 1;
          cnt_d  = cnt_q + CNTW'(1);
          if (cnt_q == DATA_LAST_C) begin
            cnt_d = '0;
            if (cmd_q == CMD_RD_BURST) begin
              // Reload while the LSB goes out, so the next MSB follows
              // without a bubble.
              sh_d     = rd_word;
              rd_ptr_d = nextPtr(rd_ptr_q);
            end else begin
              state_d = IGNORE;
            end
          end
        end

        IGNORE: begin
          state_d = IGNORE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers. Reset takes priority over SS_n.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      in_q      <= '0;
      cmd_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sh_q      <= '0;
      miso_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_q      <= in_d;
      cmd_q     <= cmd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sh_q      <= sh_d;
      miso_q    <= miso_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // RAM write port. Reset on the LSB edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wr_ptr_q[IDXW-1:0]] <= in_shift[DATA_SIZE-1:0];
  end

  assign MISO    = miso_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_burst_slave
//
// Directed bench for spi_ram_burst_slave.
//   dutA: default parameters (256 words, 8-bit address, 8-bit data)
//   dutB: 1000 words, 10-bit address, 16-bit data
// Both share one clock. Each dut has its own reset, select and MOSI, and the
// idle dut is held deselected.
// -----------------------------------------------------------------------------
module tb_spi_ram_burst_slave;

  logic clk = 1'b0;
  logic rstA, ssA, mosiA, misoA, errA;
  logic rstB, ssB, mosiB, misoB, errB;
  logic lastMiso, lastErr;
  logic [31:0] word;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_ram_burst_slave dutA (
    .clk(clk), .rst(rstA), .SS_n(ssA), .MOSI(mosiA), .MISO(misoA), .cmd_err(errA)
  );

  spi_ram_burst_slave #(.MEM_DEPTH(1000), .ADDR_SIZE(10), .DATA_SIZE(16)) dutB (
    .clk(clk), .rst(rstB), .SS_n(ssB), .MOSI(mosiB), .MISO(misoB), .cmd_err(errB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one clock edge's worth of inputs on the negedge. Outputs are
  // captured 1 time unit after the following posedge.
  task automatic applyStimulus(input int sel, input logic r, input logic ss, input logic m);
    @(negedge clk);
    if (sel == 0) begin rstA = r; ssA = ss; mosiA = m; end
    else          begin rstB = r; ssB = ss; mosiB = m; end
    @(posedge clk);
    #1;
    lastMiso = (sel == 0) ? misoA : misoB;
    lastErr  = (sel == 0) ? errA  : errB;
  endtask

  task automatic sendBits(input int sel, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(sel, 1'b0, 1'b0, v[i]);
  endtask

  task automatic endFrame(input int sel, input string tag);
    applyStimulus(sel, 1'b0, 1'b1, 1'b0);
    checkOutput({tag, " deselect miso"}, {31'b0, lastMiso}, 32'h0);
  endtask

  // Single command followed by one field (address or single data word).
  task automatic cmdField(input int sel, input logic [2:0] c, input logic [31:0] v, input int n);
    applyStimulus(sel, 1'b0, 1'b0, 1'b0);
    sendBits(sel, {29'b0, c}, 3);
    sendBits(sel, v, n);
    applyStimulus(sel, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rdData(input int sel, input int ds, input string tag, output logic [31:0] w);
    applyStimulus(sel, 1'b0, 1'b0, 1'b0);
    sendBits(sel, 32'h7, 3);
    sendBits(sel, 32'h0, ds);
    applyStimulus(sel, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " gap miso"}, {31'b0, lastMiso}, 32'h0);
    w = '0;
    for (int i = 0; i < ds; i++) begin
      applyStimulus(sel, 1'b0, 1'b0, 1'b0);
      w = {w[30:0], lastMiso};
    end
    applyStimulus(sel, 1'b0, 1'b0, 1'b1);
    checkOutput({tag, " tail miso"}, {31'b0, lastMiso}, 32'h0);
    endFrame(sel, tag);
  endtask

  task automatic readAt(input int sel, input logic [31:0] a, input int as, input int ds,
                        input string tag, input logic [31:0] exp);
    logic [31:0] w;
    cmdField(sel, 3'b110, a, as);
    rdData(sel, ds, tag, w);
    checkOutput(tag, w, exp);
  endtask

  initial begin
    rstA = 1'b1; ssA = 1'b1; mosiA = 1'b1;
    rstB = 1'b1; ssB = 1'b1; mosiB = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset A miso", {31'b0, misoA}, 32'h0);
    checkOutput("reset A err",  {31'b0, errA},  32'h0);
    checkOutput("reset B miso", {31'b0, misoB}, 32'h0);
    checkOutput("reset B err",  {31'b0, errB},  32'h0);
    @(negedge clk);
    rstA = 1'b0; rstB = 1'b0; mosiA = 1'b0; mosiB = 1'b0;

    // Pointers start at 0: write without address, read without address.
    cmdField(0, 3'b001, 32'h3C, 8);
    rdData(0, 8, "reset ptr read", word);
    checkOutput("reset ptr read word", word, 32'h3C);

    // Legacy round trip.
    cmdField(0, 3'b000, 32'hAA, 8);
    cmdField(0, 3'b001, 32'h55, 8);
    readAt(0, 32'hAA, 8, 8, "legacy AA", 32'h55);

    // Burst write across the top of memory, then burst read back.
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendBits(0, 32'h2, 3);
    sendBits(0, 32'hFE, 8);
    sendBits(0, 32'h112233, 24);
    endFrame(0, "wrburst");
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendBits(0, 32'h5, 3);
    sendBits(0, 32'hFE, 8);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("rdburst gap miso", {31'b0, lastMiso}, 32'h0);
    word = '0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      word = {word[30:0], lastMiso};
    end
    checkOutput("rdburst stream", word, 32'h112233);
    endFrame(0, "rdburst");
    readAt(0, 32'h00, 8, 8, "wrap mem00", 32'h33);
    readAt(0, 32'hFF, 8, 8, "wrap memFF", 32'h22);

    // Abort mid-word: only the completed word lands.
    cmdField(0, 3'b000, 32'h11, 8);
    cmdField(0, 3'b001, 32'h77, 8);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendBits(0, 32'h2, 3);
    sendBits(0, 32'h10, 8);
    sendBits(0, 32'hA5, 8);
    sendBits(0, 32'hF, 4);
    endFrame(0, "abort");
    readAt(0, 32'h10, 8, 8, "abort mem10", 32'hA5);
    readAt(0, 32'h11, 8, 8, "abort mem11", 32'h77);

    // Undefined command 011: single cmd_err pulse, MISO stays low.
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendBits(0, 32'h3, 3);
    checkOutput("bad011 err pulse", {31'b0, lastErr}, 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("bad011 err drop", {31'b0, lastErr}, 32'h0);
    checkOutput("bad011 miso", {31'b0, lastMiso}, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("bad011 err stays", {31'b0, lastErr}, 32'h0);
    endFrame(0, "bad011");
    // rd_ptr still 0x11 from the last read.
    rdData(0, 8, "bad011 ptr", word);
    checkOutput("bad011 ptr word", word, 32'h77);

    // Undefined command 100.
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendBits(0, 32'h4, 3);
    checkOutput("bad100 err pulse", {31'b0, lastErr}, 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("bad100 err drop", {31'b0, lastErr}, 32'h0);
    endFrame(0, "bad100");

    // Wide instance: round trip at the last address.
    cmdField(1, 3'b000, 32'd999, 10);
    cmdField(1, 3'b001, 32'hBEEF, 16);
    readAt(1, 32'd999, 10, 16, "wide 999", 32'hBEEF);

    // Out-of-range address: write dropped, read returns zero.
    cmdField(1, 3'b000, 32'd1000, 10);
    cmdField(1, 3'b001, 32'h1234, 16);
    readAt(1, 32'd1000, 10, 16, "wide 1000", 32'h0);
    readAt(1, 32'd999, 10, 16, "wide 999 intact", 32'hBEEF);

    // Wide burst wrapping from 999 to 0.
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    sendBits(1, 32'h2, 3);
    sendBits(1, 32'd999, 10);
    sendBits(1, 32'h01020304, 32);
    endFrame(1, "wide wrburst");
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    sendBits(1, 32'h5, 3);
    sendBits(1, 32'd999, 10);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    word = '0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 1'b0, 1'b0, 1'b0);
      word = {word[30:0], lastMiso};
    end
    checkOutput("wide rdburst stream", word, 32'h01020304);
    endFrame(1, "wide rdburst");

    // Reset on word 2's LSB edge.
    cmdField(0, 3'b000, 32'h41, 8);
    cmdField(0, 3'b001, 32'hC3, 8);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendBits(0, 32'h2, 3);
    sendBits(0, 32'h40, 8);
    sendBits(0, 32'h9A, 8);
    sendBits(0, 32'h35, 7);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    checkOutput("midrst miso", {31'b0, lastMiso}, 32'h0);
    checkOutput("midrst err", {31'b0, lastErr}, 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    rdData(0, 8, "midrst rdptr", word);
    checkOutput("midrst rdptr word", word, 32'h33);
    cmdField(0, 3'b001, 32'h5E, 8);
    readAt(0, 32'h00, 8, 8, "midrst wrptr", 32'h5E);
    readAt(0, 32'h40, 8, 8, "midrst mem40", 32'h9A);
    readAt(0, 32'h41, 8, 8, "midrst mem41", 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
